// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and the
// packed layout of the stage-control outputs.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // Control bundle order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
  //                        ifid_flush, idex_flush, memwb_bubble}
  localparam logic [7:0] CTRL_NORM   = 8'b11111_000;
  localparam logic [7:0] CTRL_LDUSE  = 8'b00111_010;
  localparam logic [7:0] CTRL_BRANCH = 8'b11111_110;
  localparam logic [7:0] CTRL_FREEZE = 8'b00001_001;
  localparam logic [7:0] CTRL_HALT   = 8'b00000_000;
  localparam logic [7:0] CTRL_RESET  = 8'b00000_111;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the EX-stage load writes a register that the
// ID-stage instruction is about to read. x0 never creates a dependency.
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       load_use
);

  logic [4:0] src_reg  [2];
  logic [1:0] src_used;
  logic [1:0] src_hit;

  assign src_reg[0]  = id_rs1;
  assign src_reg[1]  = id_rs2;
  assign src_used    = {id_uses_rs2, id_uses_rs1};

  // One comparator per source operand
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_reg[gi] == ex_rd);
    end
  endgenerate

  assign load_use = ex_is_load && (ex_rd != 5'd0) && (|src_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, taken-branch flushes,
// memory-wait freeze with timeout into a sticky error state.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        err,
  output logic [15:0] stall_count
);
  import pipe_pkg::*;

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [15:0] stall_count_reg;
  logic [7:0]  ctrl;
  logic        load_use;
  logic        freeze;
  logic        halt;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .load_use    (load_use)
  );

  // Next state, wait counter and stage controls; memory ready wins over timeout
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    freeze        = 1'b0;
    halt          = 1'b0;
    ctrl          = CTRL_NORM;
    case (state_reg)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze        = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next = RUN;
        end else begin
          freeze = 1'b1;
          if (({1'b0, wait_cnt_reg} + 9'd1) >= TIMEOUT_LIM)
            state_next = ERROR;
          else
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      ERROR:   halt = 1'b1;
      default: state_next = RUN;
    endcase

    // While frozen the ID/EX hazards are stale and deliberately ignored
    if (rst)                  ctrl = CTRL_RESET;
    else if (halt)            ctrl = CTRL_HALT;
    else if (freeze)          ctrl = CTRL_FREEZE;
    else if (ex_branch_taken) ctrl = CTRL_BRANCH;
    else if (load_use)        ctrl = CTRL_LDUSE;
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
          ifid_flush, idex_flush, memwb_bubble} = ctrl;
  assign err         = (state_reg == ERROR);
  assign stall_count = stall_count_reg;

  // State, wait counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      stall_count_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (!pc_en && (stall_count_reg != 16'hFFFF))
        stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table for single-cycle RUN behaviour, plus
// hand-written memory-wait, timeout, ready-priority and reset sequences.
module tb_pipe_ctrl;

  localparam logic [7:0] NORM = 8'b11111_000;
  localparam logic [7:0] LDU  = 8'b00111_010;
  localparam logic [7:0] BRF  = 8'b11111_110;
  localparam logic [7:0] FRZ  = 8'b00001_001;
  localparam logic [7:0] HLT  = 8'b00000_000;
  localparam logic [7:0] RSTV = 8'b00000_111;

  typedef struct {
    string      nm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       mq;
    logic       mr;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_bubble, err;
  logic [15:0] stall_count;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_stall;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .err             (err),
    .stall_count     (stall_count)
  );

  function automatic vec_t mk(string nm, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic [4:0] rd, logic ld,
                              logic br, logic mq, logic mr, logic [7:0] exp);
    vec_t v;
    v.nm = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.ld = ld; v.br = br; v.mq = mq; v.mr = mr; v.exp = exp;
    return v;
  endfunction

  // One transaction: drive, push expectation, compare at negedge, advance model
  task automatic step(input vec_t v, input logic r, input logic e_err);
    logic [7:0] got, e;
    rst = r;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_is_load = v.ld; ex_branch_taken = v.br;
    mem_req = v.mq; mem_ready = v.mr;
    exp_q.push_back(v.exp);
    @(negedge clk);
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_bubble};
    e = exp_q.pop_front();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b expected %b", v.nm, got, e);
    end
    n_chk++;
    if (stall_count !== exp_stall) begin
      n_fail++;
      $display("FAIL %s stall_count: got %0d expected %0d", v.nm, stall_count, exp_stall);
    end
    if (!r) begin
      n_chk++;
      if (err !== e_err) begin
        n_fail++;
        $display("FAIL %s err: got %b expected %b", v.nm, err, e_err);
      end
    end
    $display("txn %-12s rst=%b ctrl=%b err=%b stall=%0d", v.nm, r, got, err, stall_count);
    @(posedge clk);
    if (r) exp_stall = 16'd0;
    else if (!e[7] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    #1;
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = mk("no_hazard",  5'd1,  5'd2, 1, 1, 5'd3,  1, 0, 0, 0, NORM);
    tbl[1]  = mk("lduse_rs1",  5'd5,  5'd2, 1, 0, 5'd5,  1, 0, 0, 0, LDU);
    tbl[2]  = mk("x0_exempt",  5'd0,  5'd0, 1, 1, 5'd0,  1, 0, 0, 0, NORM);
    tbl[3]  = mk("lduse_rs2",  5'd1,  5'd7, 1, 1, 5'd7,  1, 0, 0, 0, LDU);
    tbl[4]  = mk("rs1_unused", 5'd5,  5'd2, 0, 1, 5'd5,  1, 0, 0, 0, NORM);
    tbl[5]  = mk("not_load",   5'd5,  5'd2, 1, 1, 5'd5,  0, 0, 0, 0, NORM);
    tbl[6]  = mk("br_over_lu", 5'd5,  5'd2, 1, 0, 5'd5,  1, 1, 0, 0, BRF);
    tbl[7]  = mk("branch",     5'd1,  5'd2, 1, 1, 5'd3,  0, 1, 0, 0, BRF);
    tbl[8]  = mk("mem_ready",  5'd1,  5'd2, 1, 1, 5'd3,  0, 0, 1, 1, NORM);
    tbl[9]  = mk("mem_rdy_lu", 5'd9,  5'd2, 1, 1, 5'd9,  1, 0, 1, 1, LDU);
    tbl[10] = mk("rs2_unused", 5'd1,  5'd7, 1, 0, 5'd7,  1, 0, 0, 0, NORM);
    tbl[11] = mk("lduse_r31",  5'd31, 5'd2, 1, 0, 5'd31, 1, 0, 0, 0, LDU);

    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_is_load = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    exp_stall = 16'd0;
    @(posedge clk); #1;

    step(mk("reset", 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0, RSTV), 1, 0);

    for (int i = 0; i < 12; i++) step(tbl[i], 0, 0);

    // Memory wait: 3 low cycles (hazards ignored while frozen), release on 4th
    for (int i = 0; i < 3; i++)
      step(mk("mw_freeze", 5'd5, 5'd2, 1, 0, 5'd5, 1, 1, 1, 0, FRZ), 0, 0);
    step(mk("mw_release", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 1, NORM), 0, 0);
    step(mk("mw_run",     5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, NORM), 0, 0);

    // Release from MEM_WAIT applies RUN rules in that cycle
    step(mk("mw2_freeze", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, FRZ), 0, 0);
    step(mk("mw2_freeze", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, FRZ), 0, 0);
    step(mk("mw2_rel_br", 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1, 1, BRF), 0, 0);

    // Ready arrives in the same cycle the timeout would fire
    for (int i = 0; i < 4; i++)
      step(mk("prio_freeze", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, FRZ), 0, 0);
    step(mk("prio_ready", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 1, NORM), 0, 0);
    step(mk("prio_run",   5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, NORM), 0, 0);

    // Timeout: RUN entry cycle plus 4 MEM_WAIT cycles, then sticky ERROR
    for (int i = 0; i < 5; i++)
      step(mk("to_freeze", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, FRZ), 0, 0);
    for (int i = 0; i < 3; i++)
      step(mk("to_error", 5'd5, 5'd2, 1, 0, 5'd5, 1, 1, 0, 1, HLT), 0, 1);
    step(mk("to_rst",   5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 1, RSTV), 1, 0);
    step(mk("to_after", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, NORM), 0, 0);

    // Reset while in MEM_WAIT
    step(mk("rmw_freeze", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, FRZ), 0, 0);
    step(mk("rmw_freeze", 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, FRZ), 0, 0);
    step(mk("rmw_rst",    5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, RSTV), 1, 0);
    step(mk("rmw_after",  5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, NORM), 0, 0);
    step(mk("rmw_lduse",  5'd4, 5'd2, 1, 0, 5'd4, 1, 0, 0, 0, LDU), 0, 0);
    step(mk("rmw_count",  5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, NORM), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
